param_shift_reg: RTL and testbench

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

---
 rtl/param_shift_reg.sv | 99 +++++++++
 tb/tb_param_shift_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with parallel load and counted bursts.
// Load and burst acceptance take one edge; an N-step burst holds busy for N cycles, then done pulses once.
module param_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_step;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic             r_done;
    logic             w_accept;
    logic             w_zero_start;
    logic             w_last;

    assign w_accept     = (r_state == S_IDLE) && !load && start && (shift_cnt != '0);
    assign w_zero_start = (r_state == S_IDLE) && !load && start && (shift_cnt == '0);
    assign w_last       = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Hold mode still consumes a count, so the step just keeps q.
    always_comb begin
        w_q_step = r_q;
        case (r_mode)
            2'b01:   w_q_step = {r_q[WIDTH-2:0], sin};
            2'b10:   w_q_step = {sin, r_q[WIDTH-1:1]};
            2'b11:   w_q_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default: w_q_step = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_mode <= 2'b00;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last || w_zero_start;
            if (r_state == S_BUSY) begin
                r_q   <= w_q_step;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (load) begin
                r_q <= d;
            end else if (w_accept) begin
                r_mode <= mode;
                r_cnt  <= shift_cnt;
            end
        end
    end

    // Latched mode persists after the burst so sout keeps tracking the last direction.
    always_comb begin
        q     = r_q;
        q_bar = ~r_q;
        busy  = (r_state == S_BUSY);
        done  = r_done;
        sout  = (r_mode == 2'b10) ? r_q[0] : r_q[WIDTH-1];
    end

endmodule

// File: tb/tb_param_shift_reg.sv
// Bench for param_shift_reg: directed scenarios plus randomized traffic against a reference model.
module tb_param_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       load;
    logic [1:0] mode;
    logic       sin;
    logic       start;
    logic [3:0] shift_cnt;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       sout;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_q    = 0;
    int m_rem  = 0;
    int m_mode = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    param_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .load      (load),
        .mode      (mode),
        .sin       (sin),
        .start     (start),
        .shift_cnt (shift_cnt),
        .q         (q),
        .q_bar     (q_bar),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        if (!rst_n) begin
            m_q = 0; m_rem = 0; m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            case (m_mode)
                1:       m_q = (m_q * 2 + int'(sin)) % 256;
                2:       m_q = m_q / 2 + int'(sin) * 128;
                3:       m_q = (m_q * 2) % 256 + m_q / 128;
                default: m_q = m_q;
            endcase
            m_rem  = m_rem - 1;
            m_done = (m_rem == 0);
            m_busy = (m_rem != 0);
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_q = int'(d);
            end else if (start) begin
                if (shift_cnt == 4'd0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_rem  = int'(shift_cnt);
                    m_mode = int'(mode);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_idle();
        d = 8'h00; load = 1'b0; mode = 2'b00; sin = 1'b0; start = 1'b0; shift_cnt = 4'd0;
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1; d = val;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b1; d = 8'hFF; start = 1'b1; shift_cnt = 4'd3; mode = 2'b01; sin = 1'b0;
        tick();
        n_checks++; if (q !== 8'h00)   begin n_fail++; $display("FAIL reset_q got %h exp 00", q); end
        n_checks++; if (q_bar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar got %h exp FF", q_bar); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout got %b exp 0", sout); end
        set_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        do_load(8'hA5);
        n_checks++; if (q !== 8'hA5)     begin n_fail++; $display("FAIL load_q got %h exp A5", q); end
        n_checks++; if (q_bar !== 8'h5A) begin n_fail++; $display("FAIL load_qbar got %h exp 5A", q_bar); end
        load = 1'b1; d = 8'h3C; start = 1'b1; shift_cnt = 4'd3; mode = 2'b01;
        tick();
        set_idle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_prio_busy got %b exp 0", busy); end
        n_checks++; if (q !== 8'h3C)   begin n_fail++; $display("FAIL load_prio_q got %h exp 3C", q); end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL load_prio_after busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
        do_load(8'h81);
        mode = 2'b11; start = 1'b1; shift_cnt = 4'd3;
        tick();
        start = 1'b0; mode = 2'b01; shift_cnt = 4'd9; sin = 1'b1;
        n_checks++; if (busy !== 1'b1 || q !== 8'h81 || done !== 1'b0) begin
            n_fail++; $display("FAIL rot_accept busy=%b q=%h done=%b exp 1 81 0", busy, q, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
                n_fail++; $display("FAIL rot_step%0d q=%h busy=%b done=%b exp %h %b %b",
                                   i, q, busy, done, exp_q[i], (i < 2), (i == 2));
            end
        end
        set_idle();
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rot_done_pulse done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_shift_right();
        do_load(8'hA5);
        mode = 2'b10; sin = 1'b1; start = 1'b1; shift_cnt = 4'd2;
        tick();
        start = 1'b0;
        n_checks++; if (sout !== 1'b1) begin n_fail++; $display("FAIL shr_sout0 got %b exp 1", sout); end
        tick();
        n_checks++; if (q !== 8'hD2 || sout !== 1'b0) begin
            n_fail++; $display("FAIL shr_step1 q=%h sout=%b exp D2 0", q, sout);
        end
        tick();
        n_checks++; if (q !== 8'hE9 || sout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL shr_step2 q=%h sout=%b done=%b busy=%b exp E9 1 1 0", q, sout, done, busy);
        end
        set_idle();
        tick();
    endtask

    task automatic test_zero_count();
        do_load(8'h5A);
        mode = 2'b01; start = 1'b1; shift_cnt = 4'd0;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h5A) begin
            n_fail++; $display("FAIL zero_cnt busy=%b done=%b q=%h exp 0 1 5A", busy, done, q);
        end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h5A) begin
            n_fail++; $display("FAIL zero_cnt_after busy=%b done=%b q=%h exp 0 0 5A", busy, done, q);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_load(8'hC3);
        mode = 2'b01; sin = 1'b1; start = 1'b1; shift_cnt = 4'd5;
        tick();
        start = 1'b0; load = 1'b1; d = 8'h00;
        tick();
        tick();
        load = 1'b0;
        n_checks++; if (q !== 8'h0F || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_burst q=%h busy=%b exp 0F 1", q, busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset q=%h busy=%b done=%b exp 00 0 0", q, busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset_quiet%0d done=%b busy=%b exp 0 0", i, done, busy);
            end
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [2] = '{8'h04, 8'h08};
        do_load(8'h01);
        mode = 2'b01; sin = 1'b0; start = 1'b1; shift_cnt = 4'd1;
        tick();
        mode = 2'b11; shift_cnt = 4'd2;
        tick();
        n_checks++; if (q !== 8'h02 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first q=%h done=%b busy=%b exp 02 1 0", q, done, busy);
        end
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h02) begin
            n_fail++; $display("FAIL b2b_accept busy=%b done=%b q=%h exp 1 0 02", busy, done, q);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (q !== exp_q[i] || done !== (i == 1)) begin
                n_fail++; $display("FAIL b2b_step%0d q=%h done=%b exp %h %b", i, q, done, exp_q[i], (i == 1));
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_max_burst();
        int busy_cycles = 0;
        do_load(8'h01);
        mode = 2'b11; start = 1'b1; shift_cnt = 4'd15;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        n_checks++; if (busy_cycles != 15 || q !== 8'h80 || done !== 1'b1) begin
            n_fail++; $display("FAIL max_burst cycles=%0d q=%h done=%b exp 15 80 1", busy_cycles, q, done);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            load      = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 2) == 0);
            mode      = 2'($urandom_range(0, 3));
            sin       = 1'($urandom_range(0, 1));
            shift_cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            d         = 8'($urandom_range(0, 255));
            tick();
            n_checks++; if (q !== 8'(m_q)) begin
                n_fail++; $display("FAIL rnd_q cyc%0d got %h exp %h", i, q, 8'(m_q));
            end
            n_checks++; if (q_bar !== ~8'(m_q)) begin
                n_fail++; $display("FAIL rnd_qbar cyc%0d got %h exp %h", i, q_bar, ~8'(m_q));
            end
            n_checks++; if (busy !== m_busy || done !== m_done) begin
                n_fail++; $display("FAIL rnd_flags cyc%0d busy=%b done=%b exp %b %b", i, busy, done, m_busy, m_done);
            end
            n_checks++; if (sout !== ((m_mode == 2) ? 1'(m_q % 2) : 1'(m_q / 128))) begin
                n_fail++; $display("FAIL rnd_sout cyc%0d got %b", i, sout);
            end
        end
        rst_n = 1'b1;
        set_idle();
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        test_reset();
        test_load();
        test_rotate();
        test_shift_right();
        test_zero_count();
        test_reset_mid_burst();
        test_back_to_back();
        test_max_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
